pipe_stall_ctrl: RTL and testbench

Central stall controller for the five-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB). It merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data SRAM wait) into the shared `StallBus` consumed by every pipeline register. It also sequences the fixed-latency iterative divider: it issues a one-cycle start, counts its latency, and holds EX until the quotient/remainder is valid. It replaces the combinational stall merge in the top level and is the single owner of `stall`.

---
 rtl/pipe_stall_ctrl_pkg.sv | 44 ++++
 rtl/pipe_stall_ctrl_div_seq.sv | 84 ++++++++
 rtl/pipe_stall_ctrl.sv | 57 +++++
 tb/tb_pipe_stall_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_stall_ctrl_pkg
// Description : Stall-bus encodings and divider sequencer state type shared
//               by the pipeline stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam int  STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam stall_bus_t STALL_MEM  = 6'b011111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_NONE = 6'b000000;

    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Highest-priority source wins: MEM, then EX divide hold, then ID load-use.
    function automatic stall_bus_t merge_stall(input logic mem_req,
                                               input logic ex_hold,
                                               input logic id_req);
        stall_bus_t s;
        if (mem_req)      s = STALL_MEM;
        else if (ex_hold) s = STALL_EX;
        else if (id_req)  s = STALL_ID;
        else              s = STALL_NONE;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_div_seq.sv
// ============================================================================
// Module      : pipe_stall_ctrl_div_seq
// Description : Fixed-latency divider sequencer: start pulse, latency count,
//               EX hold and result-valid generation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl_div_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_div_req,
    input  logic i_mem_stall,
    output logic o_div_start,
    output logic o_div_valid,
    output logic o_ex_hold
);

    localparam logic [DIV_CNT_W-1:0] c_CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 1);

    div_state_e             r_state;
    div_state_e             w_state_next;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic [DIV_CNT_W-1:0]   w_cnt_next;
    logic                   w_start;
    logic                   w_valid;
    logic                   w_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_valid      = 1'b0;
        w_hold       = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (i_div_req && !i_mem_stall) begin
                    w_start      = 1'b1;
                    w_hold       = 1'b1;
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                // Free-running regardless of MEM; DONE is entered as the count reaches zero.
                w_hold     = 1'b1;
                w_cnt_next = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                if (r_cnt <= DIV_CNT_W'(1)) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_valid = 1'b1;
                if (!i_mem_stall) begin
                    w_state_next = DIV_IDLE;
                end
            end
            default: begin
                w_state_next = DIV_IDLE;
            end
        endcase
    end

    assign o_div_start = w_start & ~rst;
    assign o_div_valid = w_valid & ~rst;
    assign o_ex_hold   = w_hold  & ~rst;

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central pipeline stall controller; merges ID/EX/MEM requests
//               into the stall bus and sequences the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stallreq,
    input  logic        ex_div_req,
    input  logic        mem_stallreq,
    output logic [5:0]  stall,
    output logic        div_start,
    output logic        div_valid,
    output logic [31:0] stall_cnt
);

    logic       w_ex_hold;
    stall_bus_t w_stall;
    logic [31:0] r_stall_cnt;

    pipe_stall_ctrl_div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk         (clk),
        .rst         (rst),
        .i_div_req   (ex_div_req),
        .i_mem_stall (mem_stallreq),
        .o_div_start (div_start),
        .o_div_valid (div_valid),
        .o_ex_hold   (w_ex_hold)
    );

    assign w_stall = rst ? STALL_NONE
                         : merge_stall(mem_stallreq, w_ex_hold, id_stallreq);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall[0] == STOP) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Directed self-checking bench for pipe_stall_ctrl (DIV_CYCLES=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stallreq;
    logic        ex_div_req;
    logic        mem_stallreq;
    logic [5:0]  stall;
    logic        div_start;
    logic        div_valid;
    logic [31:0] stall_cnt;

    int n_checks;
    int n_pass;
    int exp_cnt;

    pipe_stall_ctrl #(
        .DIV_CYCLES (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_stallreq  (id_stallreq),
        .ex_div_req   (ex_div_req),
        .mem_stallreq (mem_stallreq),
        .stall        (stall),
        .div_start    (div_start),
        .div_valid    (div_valid),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Divide held in EX from cycle 0 to 'last'; MEM stalls cycles mlo..mhi.
    task automatic run_div(input string name, input int mlo, input int mhi, input int last);
        logic [5:0] e_stall;
        for (int c = 0; c <= last; c++) begin
            ex_div_req   = 1'b1;
            mem_stallreq = (c >= mlo && c <= mhi);
            #1;
            if (mem_stallreq)  e_stall = 6'b011111;
            else if (c < 32)   e_stall = 6'b001111;
            else               e_stall = 6'b000000;
            chk($sformatf("%s stall c%0d", name, c), 32'(stall), 32'(e_stall));
            chk($sformatf("%s start c%0d", name, c), 32'(div_start), 32'(c == 0));
            chk($sformatf("%s valid c%0d", name, c), 32'(div_valid), 32'(c >= 32));
            if (e_stall[0]) exp_cnt++;
            tick();
        end
        ex_div_req   = 1'b0;
        mem_stallreq = 1'b0;
        #1;
        chk({name, " idle stall"}, 32'(stall), 32'd0);
        chk({name, " idle valid"}, 32'(div_valid), 32'd0);
        chk({name, " idle start"}, 32'(div_start), 32'd0);
        chk({name, " stall_cnt"}, stall_cnt, 32'(exp_cnt));
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        exp_cnt      = 0;
        rst          = 1'b1;
        id_stallreq  = 1'b0;
        ex_div_req   = 1'b1;
        mem_stallreq = 1'b0;
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst start", 32'(div_start), 32'd0);
        chk("rst valid", 32'(div_valid), 32'd0);
        tick();
        tick();
        chk("rst stall_cnt", stall_cnt, 32'd0);
        ex_div_req = 1'b0;
        rst        = 1'b0;

        // Quiet pipe
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("quiet stall", 32'(stall), 32'd0);
            chk("quiet start", 32'(div_start), 32'd0);
            tick();
        end
        chk("quiet stall_cnt", stall_cnt, 32'd0);

        // Single-cycle load-use
        id_stallreq = 1'b1;
        #1;
        chk("loaduse stall", 32'(stall), 32'h07);
        tick();
        exp_cnt     = 1;
        id_stallreq = 1'b0;
        #1;
        chk("loaduse after", 32'(stall), 32'd0);
        chk("loaduse stall_cnt", stall_cnt, 32'd1);

        // Plain divide; ID request concurrent with EX hold must show EX encoding
        id_stallreq = 1'b1;
        ex_div_req  = 1'b1;
        #1;
        chk("id+ex stall", 32'(stall), 32'h0f);
        id_stallreq = 1'b0;
        run_div("div", -1, -1, 32);

        // MEM stall during BUSY
        run_div("membusy", 10, 12, 32);

        // MEM stall at DONE: valid held 32..35
        run_div("memdone", 32, 34, 35);

        // Back-to-back: second div starts right after DONE with no gap
        run_div("b2b_a", -1, -1, 32);
        ex_div_req = 1'b1;
        #1;
        chk("b2b second start", 32'(div_start), 32'd1);
        chk("b2b second stall", 32'(stall), 32'h0f);
        ex_div_req = 1'b0;
        tick();

        // Reset during BUSY cycle 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        ex_div_req = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        #1;
        chk("midrst stall", 32'(stall), 32'd0);
        chk("midrst start", 32'(div_start), 32'd0);
        tick();
        rst        = 1'b0;
        ex_div_req = 1'b0;
        #1;
        chk("postrst stall", 32'(stall), 32'd0);
        chk("postrst valid", 32'(div_valid), 32'd0);
        chk("postrst stall_cnt", stall_cnt, 32'd0);
        tick();
        ex_div_req = 1'b1;
        #1;
        chk("restart start", 32'(div_start), 32'd1);
        chk("restart stall", 32'(stall), 32'h0f);
        tick();
        #1;
        chk("restart no 2nd start", 32'(div_start), 32'd0);
        chk("restart busy stall", 32'(stall), 32'h0f);
        chk("restart stall_cnt", stall_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
